dmem_responder: RTL

- Data-memory responder serving load/store requests from the 8-bit core datapath.
- The core drives address, write data and write enable; this block accepts each request through a valid/ready handshake.
- It inserts a configurable number of wait states, performs the access, and returns a response through a valid/ready handshake.
- It sits between the core and the data store and models a slow memory, so multi-cycle load/store sequencing in the controller gets exercised.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_array.sv | 25 ++
 rtl/dmem_responder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional address-range error reporting is enabled with the DMEM_ERR_EN macro.
package dmem_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage with synchronous write and synchronous (registered) read.
// Contents and the read register are deliberately not reset.
module dmem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read returns the pre-write contents when read and write hit the same word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Slow data-memory responder: accepts a load/store, waits WAIT_CYCLES, accesses the array, then holds the response.
// Define DMEM_ERR_EN to add rsp_err and reject addresses at or beyond DEPTH instead of wrapping.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy
`ifdef DMEM_ERR_EN
    ,
    output logic              rsp_err
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  next_cnt;
    logic              access;

    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              cur_write;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              cur_bad;
    logic              lat_bad;

    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

`ifdef DMEM_ERR_EN
    localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

    logic lat_err;
    logic req_oor;

    assign req_oor = ({1'b0, req_addr} >= DEPTH_LIM);
    assign lat_bad = lat_err;
    assign rsp_err = (state == RESP) && lat_err;
`else
    assign lat_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (state == IDLE && req_valid) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
        end
    end

`ifdef DMEM_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_err <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            lat_err <= req_oor;
        end
    end
`endif

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        access     = 1'b1;
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                        next_cnt   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    access     = 1'b1;
                    next_state = RESP;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // With zero wait states the access happens on the accept edge, so the live request feeds the array.
    always_comb begin
        cur_write = lat_write;
        cur_addr  = lat_addr;
        cur_wdata = lat_wdata;
        cur_bad   = lat_bad;
        if (state == IDLE) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
`ifdef DMEM_ERR_EN
            cur_bad   = req_oor;
`else
            cur_bad   = 1'b0;
`endif
        end
    end

    assign mem_we = access && cur_write && !cur_bad;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (cur_addr[IDX_W-1:0]),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    // The array keeps re-reading the latched address in RESP, so the load data stays stable under backpressure.
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = (state == RESP && !lat_write && !lat_bad) ? mem_rdata : '0;
    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE) && rst;

endmodule
